// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit (PARITY_ODD selects odd/even).
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 TX,
  output logic                 busy,
  output logic                 done
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  generate
    if (OVERSAMPLE < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
      $error("uart_tx_serializer: illegal parameter value");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                state_reg, state_next;
  logic [TICK_W-1:0]     tick_reg, tick_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg, parity_next;
`endif
  logic                  bit_end;

  assign bit_end = (tick_reg == TICK_LAST);

  always_comb begin
    state_next = state_reg;
    tick_next  = bit_end ? '0 : tick_reg + TICK_W'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        tick_next = '0;
        if (start && !busy_reg) begin
          shift_next = data;
          busy_next  = 1'b1;
          tx_next    = 1'b0;
          bit_next   = '0;
          state_next = S_START;
`ifdef UART_TX_PARITY_EN
          parity_next = (^data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          tx_next    = shift_reg[0];
          bit_next   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_reg == BIT_LAST) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
            tx_next    = parity_reg;
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            // Shift so the next data bit always sits at index 0
            bit_next   = bit_reg + BIT_W'(1);
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
          bit_next   = '0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_reg == STOP_LAST) begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            tx_next    = 1'b1;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tick_next  = '0;
        bit_next   = '0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else if (enable) begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end else begin
      // Frozen: everything holds except the done pulse
      done_reg <= 1'b0;
    end
  end

  assign TX   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
